// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline control blocks: FSM state
// encoding, the architectural zero register and canned control-output words.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        MEM_WAIT    = 2'd1,
        IRQ_ENTER   = 2'd2,
        IRQ_SERVICE = 2'd3
    } ctrl_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_flush;
        logic id_ex_bubble;
        logic pipe_hold;
        logic pc_sel_irq;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_ADVANCE = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam pipe_ctrl_t CTRL_HOLD    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam pipe_ctrl_t CTRL_RESET   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: the load in EX writes a register the ID
// instruction reads. Writes to the zero register never create a hazard.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       luse
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rt == id_rs);
    assign rt_match = id_uses_rt && (ex_rt == id_rt);
    assign luse     = ex_mem_read && (ex_rt != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Stall/flush/interrupt-entry controller for the 5-stage pipeline.
// Define HAZARD_PERF_CNT_EN to add the stall_cycles/flush_count counters.
module hazard_flush_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 16,
    parameter int unsigned WAIT_CNT_W   = 5
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    input  logic        id_jump,
    input  logic        mem_busy,
    input  logic        irq_req,
    input  logic        irq_done,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_flush,
    output logic        id_ex_bubble,
    output logic        pipe_hold,
    output logic        pc_sel_irq,
    output logic        irq_ack,
    output logic        irq_active,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
`endif
    output logic        mem_timeout
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX = WAIT_CNT_W'(MEM_WAIT_MAX);
    localparam logic [WAIT_CNT_W-1:0] WAIT_ONE = WAIT_CNT_W'(1);

    ctrl_state_t           state, state_nxt;
    logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic                  ret_service, ret_service_nxt;
    logic                  done_pend, done_pend_nxt;
    logic                  irq_ack_nxt;
    logic                  irq_active_nxt;
    logic                  mem_timeout_nxt;
    logic                  luse;
    pipe_ctrl_t            ctrl;

    hazard_detect u_hazard_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .luse        (luse)
    );

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            ret_service <= 1'b0;
            done_pend   <= 1'b0;
            irq_ack     <= 1'b0;
            irq_active  <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            ret_service <= ret_service_nxt;
            done_pend   <= done_pend_nxt;
            irq_ack     <= irq_ack_nxt;
            irq_active  <= irq_active_nxt;
            mem_timeout <= mem_timeout_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        wait_cnt_nxt    = wait_cnt;
        ret_service_nxt = ret_service;
        done_pend_nxt   = done_pend;
        irq_ack_nxt     = 1'b0;
        irq_active_nxt  = irq_active;
        mem_timeout_nxt = mem_timeout;
        ctrl            = CTRL_ADVANCE;

        if (!reset) begin
            ctrl = CTRL_RESET;
        end else begin
            unique case (state)
                RUN, IRQ_SERVICE: begin
                    if (mem_busy) begin
                        // An irq_done that collides with the stall is parked until the wait ends.
                        ctrl            = CTRL_HOLD;
                        state_nxt       = MEM_WAIT;
                        wait_cnt_nxt    = WAIT_ONE;
                        ret_service_nxt = (state == IRQ_SERVICE);
                        done_pend_nxt   = (state == IRQ_SERVICE) && irq_done;
                    end else begin
                        if (ex_branch_taken) begin
                            ctrl.if_flush     = 1'b1;
                            ctrl.id_ex_bubble = 1'b1;
                        end else if ((state == RUN) && irq_req && !irq_active) begin
                            ctrl.pc_sel_irq   = 1'b1;
                            ctrl.if_flush     = 1'b1;
                            ctrl.id_ex_bubble = 1'b1;
                            state_nxt         = IRQ_ENTER;
                            irq_ack_nxt       = 1'b1;
                        end else if (luse) begin
                            ctrl.pc_write     = 1'b0;
                            ctrl.if_id_write  = 1'b0;
                            ctrl.id_ex_bubble = 1'b1;
                        end else if (id_jump) begin
                            ctrl.if_flush     = 1'b1;
                        end

                        if ((state == IRQ_SERVICE) && irq_done) begin
                            irq_active_nxt = 1'b0;
                            state_nxt      = RUN;
                        end
                    end
                end

                MEM_WAIT: begin
                    ctrl = CTRL_HOLD;
                    if (wait_cnt != WAIT_MAX) begin
                        wait_cnt_nxt = wait_cnt + WAIT_ONE;
                    end
                    if (mem_busy && (wait_cnt == WAIT_MAX)) begin
                        mem_timeout_nxt = 1'b1;
                    end
                    if (ret_service && irq_done) begin
                        done_pend_nxt = 1'b1;
                    end
                    if (!mem_busy) begin
                        wait_cnt_nxt    = '0;
                        ret_service_nxt = 1'b0;
                        done_pend_nxt   = 1'b0;
                        if (ret_service && (done_pend || irq_done)) begin
                            irq_active_nxt = 1'b0;
                            state_nxt      = RUN;
                        end else if (ret_service) begin
                            state_nxt      = IRQ_SERVICE;
                        end else begin
                            state_nxt      = RUN;
                        end
                    end
                end

                IRQ_ENTER: begin
                    irq_active_nxt = 1'b1;
                    state_nxt      = IRQ_SERVICE;
                end

                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    assign pc_write     = ctrl.pc_write;
    assign if_id_write  = ctrl.if_id_write;
    assign if_flush     = ctrl.if_flush;
    assign id_ex_bubble = ctrl.id_ex_bubble;
    assign pipe_hold    = ctrl.pipe_hold;
    assign pc_sel_irq   = ctrl.pc_sel_irq;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!ctrl.pc_write) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (ctrl.if_flush) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule
